inst_fetch_buffer: RTL

INST_FETCH_BUFFER -- requirements
Module: inst_fetch_buffer

---
 rtl/inst_fetch_buffer.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/inst_fetch_buffer.sv
// Instruction fetch buffer: generates sequential fetch addresses, accepts the
// in-order decoded instructions returned by decode into a small circular
// queue, and presents the head entry to dispatch. Supports flush/redirect,
// stale-input rejection with a saturating drop counter, and halt on hlt.
module inst_fetch_buffer #(
  parameter int          DEPTH   = 4,
  parameter logic [11:0] HLT_OPC = 12'hFC0
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] fetch_pc,
  input  logic [11:0] in_opcode,
  input  logic [4:0]  in_rs,
  input  logic [4:0]  in_rt,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_shamt,
  input  logic [15:0] in_imm,
  input  logic [25:0] in_addr,
  input  logic [31:0] in_pc,
  input  logic        in_valid,
  output logic [11:0] out_opcode,
  output logic [4:0]  out_rs,
  output logic [4:0]  out_rt,
  output logic [4:0]  out_rd,
  output logic [4:0]  out_shamt,
  output logic [15:0] out_imm,
  output logic [25:0] out_addr,
  output logic [31:0] out_pc,
  output logic        out_valid,
  input  logic        out_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        halted,
  output logic [$clog2(DEPTH):0] count,
  output logic [15:0] drop_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL   = CW'(DEPTH);
  localparam logic [CW-1:0] MARGIN = CW'(DEPTH - 2);

  typedef struct packed {
    logic [11:0] opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [15:0] imm;
    logic [25:0] addr;
    logic [31:0] pc;
  } entry_t;

  // Saturating increment for the stale-input counter.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  entry_t          mem_q [DEPTH];
  entry_t          head_e;
  entry_t          wr_e;
  logic [PW-1:0]   head_q, head_d;
  logic [PW-1:0]   tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;
  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [31:0]     exp_pc_q, exp_pc_d;
  logic            halted_q, halted_d;
  logic [15:0]     drop_q, drop_d;
  logic            deq, accept, pc_match, stale;

  assign wr_e = '{opcode: in_opcode, rs: in_rs, rt: in_rt, rd: in_rd,
                  shamt: in_shamt, imm: in_imm, addr: in_addr, pc: in_pc};

  // Head entry is read straight out of storage; no output register.
  assign head_e     = mem_q[head_q];
  assign out_opcode = head_e.opcode;
  assign out_rs     = head_e.rs;
  assign out_rt     = head_e.rt;
  assign out_rd     = head_e.rd;
  assign out_shamt  = head_e.shamt;
  assign out_imm    = head_e.imm;
  assign out_addr   = head_e.addr;
  assign out_pc     = head_e.pc;
  assign out_valid  = (count_q != '0);
  assign fetch_pc   = fetch_pc_q;
  assign halted     = halted_q;
  assign count      = count_q;
  assign drop_cnt   = drop_q;

  // Next-state: redirect overrides everything; otherwise enqueue/dequeue/advance.
  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    fetch_pc_d = fetch_pc_q;
    exp_pc_d   = exp_pc_q;
    halted_d   = halted_q;
    drop_d     = drop_q;

    deq      = out_valid && out_ready && !redirect_valid;
    pc_match = in_valid && (in_pc == exp_pc_q);
    // Once halted, everything arriving is silently ignored (not counted as stale).
    accept   = pc_match && !redirect_valid && !halted_q && ((count_q != FULL) || deq);
    stale    = in_valid && !pc_match && !redirect_valid && !halted_q;

    if (redirect_valid) begin
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
      fetch_pc_d = redirect_pc;
      exp_pc_d   = redirect_pc;
      halted_d   = 1'b0;
    end else begin
      if (deq) head_d = head_q + PW'(1);
      if (accept) begin
        tail_d   = tail_q + PW'(1);
        exp_pc_d = exp_pc_q + 32'd1;
        if (in_opcode == HLT_OPC) halted_d = 1'b1;
      end
      case ({accept, deq})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      if (stale) drop_d = sat_inc16(drop_q);
      // Keep one slot free for the instruction already inside decode.
      if (!halted_q && (count_q <= MARGIN)) fetch_pc_d = fetch_pc_q + 32'd1;
    end
  end

  // Control state with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      fetch_pc_q <= '0;
      exp_pc_q   <= '0;
      halted_q   <= 1'b0;
      drop_q     <= '0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      fetch_pc_q <= fetch_pc_d;
      exp_pc_q   <= exp_pc_d;
      halted_q   <= halted_d;
      drop_q     <= drop_d;
    end
  end

  // Entry storage: written on accept only, never reset.
  always_ff @(posedge clk) begin
    if (accept) mem_q[tail_q] <= wr_e;
  end

endmodule
